t_ff_pos_rst_n_by_jkff: RTL and testbench

T_FF_POS_RST_N_BY_JKFF -- requirements
Module: t_ff_pos_rst_n_by_jkff

---
 rtl/t_ff_pos_rst_n_by_jkff.sv | 36 +++
 tb/tb_t_ff_pos_rst_n_by_jkff.sv | 134 +++++++++++++
 2 files changed

// File: rtl/t_ff_pos_rst_n_by_jkff.sv
// T flip-flop built from an internal JK stage with J and K both tied to T.
// Synchronous active-high reset loads RESET_Q; Qn is always the complement of Q.
module t_ff_pos_rst_n_by_jkff #(
  parameter logic RESET_Q = 1'b0
) (
  input  logic T,
  input  logic clk,
  input  logic rst,
  output logic Q,
  output logic Qn
);

  logic q_q;
  logic q_d;

  // JK stage: J=K=T makes the hold/toggle cases the only reachable ones.
  always_comb begin : jk_stage
    logic j;
    logic k;
    j   = T;
    k   = T;
    q_d = (j & ~q_q) | (~k & q_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= RESET_Q;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q  = q_q;
  assign Qn = ~q_q;

endmodule

// File: tb/tb_t_ff_pos_rst_n_by_jkff.sv
// Self-checking bench: two DUTs (RESET_Q=0 and RESET_Q=1) share stimulus; expected
// values come from a vector table and hand sequences via a scoreboard queue.
module tb_t_ff_pos_rst_n_by_jkff;

  logic clk;
  logic rst;
  logic t_in;
  logic q0, qn0, q1, qn1;

  int unsigned n_checks;
  int unsigned n_errors;

  typedef struct packed {
    logic e0;
    logic e1;
  } exp_t;

  typedef struct packed {
    logic t;
    logic r;
    logic e0;
    logic e1;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[12];

  t_ff_pos_rst_n_by_jkff #(.RESET_Q(1'b0)) u_dut0 (
    .T   (t_in),
    .clk (clk),
    .rst (rst),
    .Q   (q0),
    .Qn  (qn0)
  );

  t_ff_pos_rst_n_by_jkff #(.RESET_Q(1'b1)) u_dut1 (
    .T   (t_in),
    .clk (clk),
    .rst (rst),
    .Q   (q1),
    .Qn  (qn1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic e0, input logic e1);
    logic [3:0] act;
    logic [3:0] req;
    act = {q0, qn0, q1, qn1};
    req = {e0, ~e0, e1, ~e1};
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: {Q0,Qn0,Q1,Qn1} got %b want %b at %0t", name, act, req, $time);
    end
  endtask

  task automatic expect_edge(input string name, input logic e0, input logic e1);
    exp_t e;
    sb.push_back('{e0: e0, e1: e1});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check(name, e.e0, e.e1);
  endtask

  task automatic step(input string name, input logic t, input logic r,
                      input logic e0, input logic e1);
    @(negedge clk);
    t_in = t;
    rst  = r;
    expect_edge(name, e0, e1);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    t_in = 1'b0;
    rst  = 1'b1;

    // Reset with T toggling, then divide-by-2, then one toggle and hold.
    vecs[0]  = '{t: 1'b1, r: 1'b1, e0: 1'b0, e1: 1'b1};
    vecs[1]  = '{t: 1'b0, r: 1'b1, e0: 1'b0, e1: 1'b1};
    vecs[2]  = '{t: 1'b1, r: 1'b1, e0: 1'b0, e1: 1'b1};
    vecs[3]  = '{t: 1'b0, r: 1'b1, e0: 1'b0, e1: 1'b1};
    vecs[4]  = '{t: 1'b1, r: 1'b0, e0: 1'b1, e1: 1'b0};
    vecs[5]  = '{t: 1'b1, r: 1'b0, e0: 1'b0, e1: 1'b1};
    vecs[6]  = '{t: 1'b1, r: 1'b0, e0: 1'b1, e1: 1'b0};
    vecs[7]  = '{t: 1'b1, r: 1'b0, e0: 1'b0, e1: 1'b1};
    vecs[8]  = '{t: 1'b1, r: 1'b0, e0: 1'b1, e1: 1'b0};
    vecs[9]  = '{t: 1'b0, r: 1'b0, e0: 1'b1, e1: 1'b0};
    vecs[10] = '{t: 1'b0, r: 1'b0, e0: 1'b1, e1: 1'b0};
    vecs[11] = '{t: 1'b0, r: 1'b0, e0: 1'b1, e1: 1'b0};

    for (int i = 0; i < 12; i++) begin
      step($sformatf("vec%0d", i), vecs[i].t, vecs[i].r, vecs[i].e0, vecs[i].e1);
    end

    // T pulse entirely between edges must be ignored.
    #2 t_in = 1'b1;
    #1 check("mid_pulse_hold", 1'b1, 1'b0);
    #1 t_in = 1'b0;
    step("pulse_between_edges", 1'b0, 1'b0, 1'b1, 1'b0);

    // rst rising mid-cycle with T=1 acts only at the next edge.
    t_in = 1'b1;
    #2 rst = 1'b1;
    #1 check("rst_mid_no_effect", 1'b1, 1'b0);
    #2 check("rst_negedge_no_effect", 1'b1, 1'b0);
    expect_edge("rst_at_edge", 1'b0, 1'b1);

    // rst falling mid-cycle also waits for the edge; then normal toggle from reset value.
    #2 rst = 1'b0;
    #1 check("rst_release_mid", 1'b0, 1'b1);
    expect_edge("first_edge_after_rst", 1'b1, 1'b0);
    step("toggle_after_rst", 1'b1, 1'b0, 1'b0, 1'b1);
    step("hold_after_toggle", 1'b0, 1'b0, 1'b0, 1'b1);

    // Single-edge reset, then a single toggle.
    step("single_rst", 1'b1, 1'b1, 1'b0, 1'b1);
    step("single_toggle", 1'b1, 1'b0, 1'b1, 1'b0);

    if (sb.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d entries want 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
